// File: rtl/premuat_pipe.sv
// Registered even/odd lane permutation (forward interleave / inverse split) for N = 4/8/16/32
// lanes, with a one-deep valid/ready output stage and an accepted-beat counter.
module premuat_pipe #(
  parameter int unsigned W     = 28,
  parameter int unsigned N_MAX = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic               i_enable,
  input  logic               i_inverse,
  input  logic [1:0]         i_size,
  input  logic               i_last,
  input  logic [N_MAX*W-1:0] i_data,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [N_MAX*W-1:0] o_data,
  output logic               o_last,
  output logic               o_size_err,
  output logic [15:0]        o_beats
);

  // Source lane feeding output lane k; lanes at or beyond n are fixed points.
  function automatic int unsigned src_lane(input int unsigned k, input int unsigned n,
                                           input logic inv);
    int unsigned h;
    h = n >> 32'd1;
    if (k >= n) begin
      src_lane = k;
    end else if (inv) begin
      src_lane = (k < h) ? (k << 32'd1) : (((k - h) << 32'd1) + 32'd1);
    end else begin
      src_lane = (k[0] == 1'b0) ? (k >> 32'd1) : (h + (k >> 32'd1));
    end
  endfunction

  int unsigned        n_s;
  logic               size_err_s;
  logic               accept_s;
  logic [N_MAX*W-1:0] perm_s;

  logic               valid_q, valid_d;
  logic [N_MAX*W-1:0] data_q, data_d;
  logic               last_q, last_d;
  logic               size_err_q, size_err_d;
  logic [15:0]        beats_q, beats_d;

  assign i_ready  = ~valid_q | o_ready;
  assign accept_s = i_valid & i_ready;

  // Lane permutation of the incoming beat; oversize or disabled beats pass as identity.
  always_comb begin
    n_s        = 32'd4 << i_size;
    size_err_s = (n_s > N_MAX);
    perm_s     = i_data;
    for (int unsigned k = 0; k < N_MAX; k++) begin
      if (i_enable && !size_err_s) begin
        perm_s[k*W +: W] = i_data[src_lane(k, n_s, i_inverse)*W +: W];
      end else begin
        perm_s[k*W +: W] = i_data[k*W +: W];
      end
    end
  end

  // Output stage next state: a push overwrites the held beat, a lone pop only clears valid.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    size_err_d = size_err_q;
    beats_d    = beats_q;
    if (accept_s) begin
      valid_d    = 1'b1;
      data_d     = perm_s;
      last_d     = i_last;
      size_err_d = size_err_s;
      beats_d    = beats_q + 16'd1;
    end else if (o_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      size_err_q <= 1'b0;
      beats_q    <= 16'd0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      size_err_q <= size_err_d;
      beats_q    <= beats_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_last     = last_q;
  assign o_size_err = size_err_q;
  assign o_beats    = beats_q;

endmodule

// File: tb/tb_premuat_pipe.sv
// Randomized and directed bench for premuat_pipe; a list-based lane model plus a beat queue
// predict every output.
module tb_premuat_pipe;
  localparam int W   = 28;
  localparam int NM  = 32;
  localparam int DW  = NM * W;
  localparam int NB  = 16;
  localparam int DWB = NB * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_valid, i_ready, i_enable, i_inverse, i_last;
  logic [1:0]    i_size;
  logic [DW-1:0] i_data, o_data;
  logic          o_valid, o_ready, o_last, o_size_err;
  logic [15:0]   o_beats;

  logic           b_i_valid, b_i_ready, b_i_enable, b_i_inverse, b_i_last;
  logic [1:0]     b_i_size;
  logic [DWB-1:0] b_i_data, b_o_data;
  logic           b_o_valid, b_o_ready, b_o_last, b_o_size_err;
  logic [15:0]    b_o_beats;

  premuat_pipe #(.W(W), .N_MAX(NM)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_enable(i_enable),
    .i_inverse(i_inverse), .i_size(i_size), .i_last(i_last), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
    .o_size_err(o_size_err), .o_beats(o_beats));

  premuat_pipe #(.W(W), .N_MAX(NB)) dut16 (
    .clk(clk), .rst(rst), .i_valid(b_i_valid), .i_ready(b_i_ready), .i_enable(b_i_enable),
    .i_inverse(b_i_inverse), .i_size(b_i_size), .i_last(b_i_last), .i_data(b_i_data),
    .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .o_last(b_o_last),
    .o_size_err(b_o_size_err), .o_beats(b_o_beats));

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          e;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] nbeats;
  int          npops;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: build the output as lists (evens then odds, or alternate the two halves).
  function automatic logic [DW-1:0] ref_perm(input logic [DW-1:0] din, input logic inv,
                                             input logic en, input logic [1:0] sz,
                                             input int nmax, output logic err);
    logic [W-1:0] a[NM];
    logic [W-1:0] o[NM];
    logic [DW-1:0] r;
    int n, h;
    n = 4 << sz;
    h = n / 2;
    for (int k = 0; k < NM; k++) begin
      a[k] = din[k*W +: W];
      o[k] = a[k];
    end
    err = (n > nmax);
    if (en && !err) begin
      for (int j = 0; j < h; j++) begin
        if (inv) begin
          o[j]     = a[2*j];
          o[h + j] = a[2*j + 1];
        end else begin
          o[2*j]     = a[j];
          o[2*j + 1] = a[h + j];
        end
      end
    end
    for (int k = 0; k < NM; k++) r[k*W +: W] = o[k];
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp();
    logic [DW-1:0] r;
    for (int k = 0; k < NM; k++) r[k*W +: W] = W'(k);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data(input int tag);
    logic [DW-1:0] r;
    for (int k = 0; k < NM; k++) r[k*W +: W] = W'($urandom);
    r[W-1:0] = W'(tag);
    return r;
  endfunction

  // Called just after inputs change at negedge: checks outputs, updates model, waits posedge.
  task automatic step(output bit pushed);
    bit pop, push;
    beat_t e;
    #1;
    pop  = o_valid && o_ready;
    push = i_valid && i_ready;
    check_val("o_valid", DW'(o_valid), DW'(exp_q.size() != 0));
    check_val("i_ready", DW'(i_ready), DW'((exp_q.size() == 0) || o_ready));
    check_val("o_beats", DW'(o_beats), DW'(nbeats));
    if (exp_q.size() != 0) begin
      check_val("o_data", o_data, exp_q[0].d);
      check_val("o_last", DW'(o_last), DW'(exp_q[0].l));
      check_val("o_size_err", DW'(o_size_err), DW'(exp_q[0].e));
    end
    if (pop && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      npops++;
    end
    if (push) begin
      e.d = ref_perm(i_data, i_inverse, i_enable, i_size, NM, e.e);
      e.l = i_last;
      exp_q.push_back(e);
      nbeats = nbeats + 16'd1;
    end
    pushed = push;
    @(posedge clk);
  endtask

  task automatic drive(input bit v, input bit en, input bit inv, input bit [1:0] sz,
                       input bit last, input logic [DW-1:0] d, input bit rdy, output bit pushed);
    @(negedge clk);
    i_valid   = v;
    i_enable  = en;
    i_inverse = inv;
    i_size    = sz;
    i_last    = last;
    i_data    = d;
    o_ready   = rdy;
    step(pushed);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    nbeats = 16'd0;
    npops  = 0;
  endtask

  logic [DW-1:0] d, t1, ex;
  bit            pushed;
  int            beat, cyc;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_enable = 1'b1; i_inverse = 1'b0; i_size = 2'd0;
    i_last = 1'b0; i_data = '0; o_ready = 1'b0;
    b_i_valid = 1'b0; b_i_enable = 1'b1; b_i_inverse = 1'b0; b_i_size = 2'd0;
    b_i_last = 1'b0; b_i_data = '0; b_o_ready = 1'b1;
    nbeats = 16'd0; npops = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state, first cycle after reset.
    #1;
    check_val("rst_valid", DW'(o_valid), DW'(0));
    check_val("rst_data", o_data, '0);
    check_val("rst_last", DW'(o_last), DW'(0));
    check_val("rst_err", DW'(o_size_err), DW'(0));
    check_val("rst_beats", DW'(o_beats), DW'(0));
    check_val("rst_ready", DW'(i_ready), DW'(1));

    // Test 1: inverse N=32 on a ramp.
    drive(1, 1, 1, 2'd3, 0, ramp(), 1, pushed);
    @(negedge clk); i_valid = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) begin
      ex[k*W +: W]        = W'(2 * k);
      ex[(16 + k)*W +: W] = W'(2 * k + 1);
    end
    check_val("t1_inv32", o_data, ex);
    check_val("t1_valid", DW'(o_valid), DW'(1));
    t1 = o_data;
    step(pushed);

    // Test 2: forward N=32 on a ramp, then chain test 1's output back to identity.
    drive(1, 1, 0, 2'd3, 0, ramp(), 1, pushed);
    @(negedge clk); i_valid = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) begin
      ex[(2*k)*W +: W]     = W'(k);
      ex[(2*k + 1)*W +: W] = W'(16 + k);
    end
    check_val("t2_fwd32", o_data, ex);
    step(pushed);
    drive(1, 1, 0, 2'd3, 0, t1, 1, pushed);
    @(negedge clk); i_valid = 1'b0;
    #1;
    check_val("t2_chain", o_data, ramp());
    step(pushed);

    // Test 3: inverse N=8 with a negative lane; upper lanes untouched.
    d = ramp();
    d[2*W +: W] = 28'hFFFFFFB;
    drive(1, 1, 1, 2'd1, 0, d, 1, pushed);
    @(negedge clk); i_valid = 1'b0;
    #1;
    check_val("t3_neg_lane1", DW'(o_data[W +: W]), DW'(28'hFFFFFFB));
    check_val("t3_lane4", DW'(o_data[4*W +: W]), DW'(1));
    check_val("t3_hi_lanes", DW'(o_data[DW-1:8*W]), DW'(d[DW-1:8*W]));
    step(pushed);

    // Enable low: identity regardless of mode/size.
    drive(1, 0, 1, 2'd3, 0, ramp(), 1, pushed);
    @(negedge clk); i_valid = 1'b0;
    #1;
    check_val("en0_ident", o_data, ramp());
    step(pushed);

    // Test 4: 10 beats under backpressure.
    do_reset();
    beat = 0;
    cyc  = 0;
    while (beat < 10 && cyc < 200) begin
      drive(1, 1, 1'($urandom), 2'($urandom), beat == 9, rand_data(beat), (cyc % 3) == 0, pushed);
      if (pushed) beat++;
      cyc++;
    end
    check_val("t4_timeout", DW'(beat), DW'(10));
    repeat (4) drive(0, 1, 0, 2'd0, 0, '0, 1, pushed);
    #1;
    check_val("t4_beats", DW'(o_beats), DW'(10));
    check_val("t4_pops", DW'(npops), DW'(10));

    // Test 5: N_MAX=16 build, oversize beat then legal beat.
    @(negedge clk);
    b_i_valid = 1'b1; b_i_enable = 1'b1; b_i_inverse = 1'b1; b_i_size = 2'd3;
    b_i_data  = DWB'(ramp());
    @(posedge clk);
    #1;
    check_val("t5_err1", DW'(b_o_size_err), DW'(1));
    check_val("t5_ident", DW'(b_o_data), DW'(DWB'(ramp())));
    @(negedge clk);
    b_i_size = 2'd2;
    @(posedge clk);
    #1;
    ex = ref_perm(DW'(DWB'(ramp())), 1'b1, 1'b1, 2'd2, NB, t1[0]);
    check_val("t5_err0", DW'(b_o_size_err), DW'(0));
    check_val("t5_perm16", DW'(b_o_data), DW'(DWB'(ex)));
    @(negedge clk);
    b_i_valid = 1'b0;

    // Test 6: reset while a beat is stalled.
    drive(1, 1, 0, 2'd2, 1, ramp(), 0, pushed);
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    @(posedge clk);
    #1;
    check_val("t6_valid", DW'(o_valid), DW'(0));
    check_val("t6_beats", DW'(o_beats), DW'(0));
    check_val("t6_ready", DW'(i_ready), DW'(1));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    nbeats = 16'd0;
    npops  = 0;

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      drive(1'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom),
            1'($urandom), rand_data(c), 1'($urandom), pushed);
    end
    repeat (3) drive(0, 1, 0, 2'd0, 0, '0, 1, pushed);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
